sme_feeder: RTL

- Stimulus-side counterpart of the SME string-matching engine. A host loads a string (1..32 chars) and a pattern (1..8 chars) into local buffers.
- sme_feeder then streams them on the SME input bus (chardata/isstring/ispattern), waits for SME valid, and returns match/match_index to the host over a ready/valid result handshake.
- Sits between a host/controller and SME; replaces file-driven stimulus in system-level use.

---
 rtl/sme_pkg.sv | 12 +
 rtl/sme_feeder_if.sv | 34 +++
 rtl/sme_char_buf.sv | 20 ++
 rtl/sme_feeder.sv | 89 ++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// sme_pkg: shared types and widths for the SME stimulus feeder.
package sme_pkg;
  localparam int STR_IDX_W = 5;
  localparam int PAT_IDX_W = 3;
  localparam int CHAR_W = 8;
  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, RESULT} state_t;
  typedef struct packed {
    logic match;
    logic [STR_IDX_W-1:0] index;
    logic timeout;
  } result_t;
endpackage

// File: rtl/sme_feeder_if.sv
// sme_feeder_if: host buffer/command port, SME input bus and result handshake.
interface sme_feeder_if;
  import sme_pkg::*;
  logic wr_en;
  logic wr_sel;
  logic [STR_IDX_W-1:0] wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic start;
  logic new_str;
  logic [STR_IDX_W-1:0] str_len_m1;
  logic [PAT_IDX_W-1:0] pat_len_m1;
  logic busy;
  logic [CHAR_W-1:0] chardata;
  logic isstring;
  logic ispattern;
  logic sme_valid;
  logic sme_match;
  logic [STR_IDX_W-1:0] sme_index;
  logic res_valid;
  logic res_ready;
  logic res_match;
  logic [STR_IDX_W-1:0] res_index;
  logic res_timeout;
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, new_str, str_len_m1, pat_len_m1,
    output sme_valid, sme_match, sme_index, res_ready,
    input busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout
  );
  modport slave (
    input wr_en, wr_sel, wr_addr, wr_data, start, new_str, str_len_m1, pat_len_m1,
    input sme_valid, sme_match, sme_index, res_ready,
    output busy, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout
  );
endinterface

// File: rtl/sme_char_buf.sv
// sme_char_buf: depth x char register file, one write port, write-first async read port.
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [CHAR_W-1:0] rdata
);
  logic [CHAR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // forwarding lets a write issued alongside start reach the first streamed char
  assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/sme_feeder.sv
// sme_feeder: streams buffered string/pattern to SME and returns its result to the host.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  sme_feeder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  state_t state, state_n;
  logic [STR_IDX_W-1:0] idx, idx_n, idx_inc, str_len, str_len_n;
  logic [PAT_IDX_W-1:0] pat_len, pat_len_n;
  logic [TW-1:0] tmo, tmo_n, tmo_inc;
  logic [CHAR_W-1:0] str_rd, pat_rd, char_n;
  logic busy_n, isstr_n, ispat_n, res_valid_n, wr_ok, go, str_last, pat_last;
  result_t res, res_n;
  assign wr_ok = bus.wr_en && !bus.busy;
  assign go = state == IDLE && bus.start;
  assign idx_inc = idx + 1'b1;
  assign tmo_inc = tmo + 1'b1;
  assign str_last = idx == str_len;
  assign pat_last = idx[PAT_IDX_W-1:0] == pat_len;
  sme_char_buf #(.DEPTH(STR_MAX)) u_str (
    .clk, .we(wr_ok && !bus.wr_sel), .waddr(SAW'(bus.wr_addr)), .wdata(bus.wr_data),
    .raddr(state == SEND_STR ? SAW'(idx_inc) : '0), .rdata(str_rd)
  );
  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat (
    .clk, .we(wr_ok && bus.wr_sel), .waddr(PAW'(bus.wr_addr)), .wdata(bus.wr_data),
    .raddr(state == SEND_PAT ? PAW'(idx_inc) : '0), .rdata(pat_rd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      tmo <= '0;
      str_len <= '0;
      pat_len <= '0;
      res <= '0;
      bus.busy <= 1'b0;
      bus.chardata <= '0;
      bus.isstring <= 1'b0;
      bus.ispattern <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      tmo <= tmo_n;
      str_len <= str_len_n;
      pat_len <= pat_len_n;
      res <= res_n;
      bus.busy <= busy_n;
      bus.chardata <= char_n;
      bus.isstring <= isstr_n;
      bus.ispattern <= ispat_n;
      bus.res_valid <= res_valid_n;
    end
  always_comb begin
    state_n = state == IDLE     ? (bus.start ? (bus.new_str ? SEND_STR : SEND_PAT) : IDLE)
            : state == SEND_STR ? (str_last ? SEND_PAT : SEND_STR)
            : state == SEND_PAT ? (pat_last ? WAIT : SEND_PAT)
            : state == WAIT     ? (bus.sme_valid || tmo_inc == TW'(TIMEOUT) ? RESULT : WAIT)
            : state == RESULT   ? (bus.res_ready ? IDLE : RESULT)
            : IDLE;
  end
  // outputs are next-cycle register values, so they follow state_n rather than state
  always_comb begin
    idx_n = (go || (state == SEND_STR && str_last)) ? '0 : idx_inc;
    tmo_n = state == WAIT ? tmo_inc : '0;
    str_len_n = go ? bus.str_len_m1 : str_len;
    pat_len_n = go ? bus.pat_len_m1 : pat_len;
    isstr_n = state_n == SEND_STR;
    ispat_n = state_n == SEND_PAT;
    char_n = state_n == SEND_STR ? str_rd : state_n == SEND_PAT ? pat_rd : bus.chardata;
    busy_n = state_n != IDLE;
    res_valid_n = state_n == RESULT;
    res_n = (state == WAIT && bus.sme_valid) ? result_t'{match: bus.sme_match, index: bus.sme_index, timeout: 1'b0}
          : (state == WAIT && state_n == RESULT) ? result_t'{match: 1'b0, index: '0, timeout: 1'b1}
          : res;
  end
  assign bus.res_match = res.match;
  assign bus.res_index = res.index;
  assign bus.res_timeout = res.timeout;
endmodule
